airbag_deploy_ctrl: RTL

//  Multi-zone sequential airbag deployment controller, successor to the single-zone

---
 rtl/airbag_deploy_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/airbag_deploy_ctrl.sv
// Multi-zone airbag deployment controller.
// Each zone confirms its qualified crash sensor over a window of consecutive samples,
// fires a fixed-width pulse, then stays locked out until reset.
module airbag_deploy_ctrl #(
  parameter int unsigned N_ZONES        = 4,
  parameter int unsigned CONFIRM_CYCLES = 4,
  parameter int unsigned FIRE_CYCLES    = 8,
  parameter int unsigned CNT_W          = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_arm,
  input  logic [N_ZONES-1:0] i_sensor,
  input  logic [N_ZONES-1:0] i_seatbelt,
  input  logic               i_brake,
  output logic [N_ZONES-1:0] o_airbag,
  output logic [N_ZONES-1:0] o_deployed,
  output logic               o_any_fire
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONFIRM = 2'd1;
  localparam logic [1:0] S_FIRE    = 2'd2;
  localparam logic [1:0] S_SPENT   = 2'd3;

  localparam logic [CNT_W-1:0] CONFIRM_LAST = CNT_W'(CONFIRM_CYCLES - 1);
  localparam logic [CNT_W-1:0] FIRE_LAST    = CNT_W'(FIRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = '0;
  localparam bit               SKIP_CONFIRM = (CONFIRM_CYCLES == 1);

  logic [1:0]       r_state     [N_ZONES];
  logic [1:0]       w_state_nxt [N_ZONES];
  logic [CNT_W-1:0] r_cnt       [N_ZONES];
  logic [CNT_W-1:0] w_cnt_nxt   [N_ZONES];

  logic [N_ZONES-1:0] w_qual;
  logic [N_ZONES-1:0] w_airbag_nxt;
  logic [N_ZONES-1:0] w_deployed_nxt;
  logic [N_ZONES-1:0] r_airbag;
  logic [N_ZONES-1:0] r_deployed;
  logic               r_any_fire;

  // Per-zone qualification: armed, sensor hit, occupant belted, brake active.
  assign w_qual = {N_ZONES{i_arm & i_brake}} & i_sensor & i_seatbelt;

  // Next-state, counter and registered-output decode for every zone.
  always_comb begin
    for (int i = 0; i < N_ZONES; i++) begin
      w_state_nxt[i]    = r_state[i];
      w_cnt_nxt[i]      = r_cnt[i];
      w_airbag_nxt[i]   = 1'b0;
      w_deployed_nxt[i] = 1'b0;

      case (r_state[i])
        S_IDLE: begin
          if (w_qual[i]) begin
            if (SKIP_CONFIRM) begin
              w_state_nxt[i] = S_FIRE;
              w_cnt_nxt[i]   = CNT_ZERO;
            end else begin
              w_state_nxt[i] = S_CONFIRM;
              w_cnt_nxt[i]   = CNT_ONE;
            end
          end
        end
        S_CONFIRM: begin
          if (!w_qual[i]) begin
            w_state_nxt[i] = S_IDLE;
            w_cnt_nxt[i]   = CNT_ZERO;
          end else if (r_cnt[i] == CONFIRM_LAST) begin
            w_state_nxt[i] = S_FIRE;
            w_cnt_nxt[i]   = CNT_ZERO;
          end else begin
            w_cnt_nxt[i]   = r_cnt[i] + CNT_ONE;
          end
        end
        S_FIRE: begin
          // Once firing, inputs no longer matter: the pulse always completes.
          if (r_cnt[i] == FIRE_LAST) begin
            w_state_nxt[i] = S_SPENT;
            w_cnt_nxt[i]   = CNT_ZERO;
          end else begin
            w_cnt_nxt[i]   = r_cnt[i] + CNT_ONE;
          end
        end
        S_SPENT: begin
          w_state_nxt[i] = S_SPENT;
        end
        default: begin
          w_state_nxt[i] = S_IDLE;
          w_cnt_nxt[i]   = CNT_ZERO;
        end
      endcase

      w_airbag_nxt[i]   = (w_state_nxt[i] == S_FIRE);
      w_deployed_nxt[i] = (w_state_nxt[i] == S_FIRE) || (w_state_nxt[i] == S_SPENT);
    end
  end

  // State, counters and outputs; synchronous reset rearms every zone.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_ZONES; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= CNT_ZERO;
      end
      r_airbag   <= '0;
      r_deployed <= '0;
      r_any_fire <= 1'b0;
    end else begin
      for (int i = 0; i < N_ZONES; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      r_airbag   <= w_airbag_nxt;
      r_deployed <= w_deployed_nxt;
      r_any_fire <= |w_airbag_nxt;
    end
  end

  assign o_airbag   = r_airbag;
  assign o_deployed = r_deployed;
  assign o_any_fire = r_any_fire;

endmodule
